can_tx_cdc_handshake: RTL

CAN_TX_CDC_HANDSHAKE -- requirements
Module: can_tx_cdc_handshake

---
 rtl/can_cdc_pkg.sv | 22 ++
 rtl/can_bit_sync.sv | 32 +++
 rtl/can_tx_cdc_handshake.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/can_cdc_pkg.sv
// ---------------------------------------------------------------------------
// can_cdc_pkg
// Shared definitions for the CAN TX clock-domain-crossing handshake.
//   sys_state_t         : source (i_sys_clk) side FSM states
//   can_state_t         : destination (i_can_clk) side FSM states
//   SYNC_STAGES_DEFAULT : default flop count of each single-bit synchronizer
// ---------------------------------------------------------------------------
package can_cdc_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } sys_state_t;

    typedef enum logic {
        C_IDLE    = 1'b0,
        C_PRESENT = 1'b1
    } can_state_t;

endpackage

// File: rtl/can_bit_sync.sv
// ---------------------------------------------------------------------------
// can_bit_sync
// N-stage single-bit synchronizer with asynchronous active-high reset.
//   i_clk   : destination clock
//   i_reset : asynchronous reset, clears every stage to 0
//   i_d     : asynchronous single-bit input
//   o_q     : synchronized output (last stage)
// STAGES must lie in 2..4. The same block doubles as a reset-release
// synchronizer when i_d is tied to 1 (o_q then acts as an active-low reset).
// ---------------------------------------------------------------------------
module can_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_reg[STAGES-1];

endmodule

// File: rtl/can_tx_cdc_handshake.sv
// ---------------------------------------------------------------------------
// can_tx_cdc_handshake
// Moves one DATA_W-bit TX request word from the system clock domain to the
// CAN controller clock domain with a toggle request/acknowledge handshake.
// Only req_tgl and ack_tgl cross through synchronizers; the word itself sits
// in a hold register that is stable for the whole handshake, so the CAN side
// samples it directly once it has seen the request toggle.
//
// Ports
//   i_sys_clk    : system (source) clock
//   i_can_clk    : CAN (destination) clock, unrelated to i_sys_clk
//   i_reset      : asynchronous active-high reset for both domains
//   i_tx_valid   : sys: word offered
//   i_tx_data    : sys: word to transfer
//   o_tx_ready   : sys: no transfer pending (S_IDLE)
//   o_tx_done    : sys: one-cycle pulse once the CAN side consumed the word
//   o_can_valid  : can: word available, held until accepted
//   o_can_data   : can: transferred word, stable while o_can_valid is high
//   i_can_accept : can: consumer takes the word
// ---------------------------------------------------------------------------
module can_tx_cdc_handshake
    import can_cdc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              i_sys_clk,
    input  logic              i_can_clk,
    input  logic              i_reset,
    input  logic              i_tx_valid,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_tx_ready,
    output logic              o_tx_done,
    output logic              o_can_valid,
    output logic [DATA_W-1:0] o_can_data,
    input  logic              i_can_accept
);

    // Per-domain reset: asserts asynchronously with i_reset, releases only
    // after SYNC_STAGES edges of the local clock.
    logic sys_rst_n;
    logic can_rst_n;
    logic sys_rst;
    logic can_rst;

    can_bit_sync #(.STAGES(SYNC_STAGES)) u_sys_rst_sync (
        .i_clk   (i_sys_clk),
        .i_reset (i_reset),
        .i_d     (1'b1),
        .o_q     (sys_rst_n)
    );

    can_bit_sync #(.STAGES(SYNC_STAGES)) u_can_rst_sync (
        .i_clk   (i_can_clk),
        .i_reset (i_reset),
        .i_d     (1'b1),
        .o_q     (can_rst_n)
    );

    assign sys_rst = ~sys_rst_n;
    assign can_rst = ~can_rst_n;

    // ------------------------------------------------------------------
    // System domain
    // ------------------------------------------------------------------
    sys_state_t        sys_state_reg, sys_state_next;
    logic              req_tgl_reg, req_tgl_next;
    logic [DATA_W-1:0] hold_reg, hold_next;
    logic              done_reg, done_next;
    logic              ack_sync;

    logic              ack_tgl_reg;
    logic              req_sync;

    can_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .i_clk   (i_sys_clk),
        .i_reset (sys_rst),
        .i_d     (ack_tgl_reg),
        .o_q     (ack_sync)
    );

    always_ff @(posedge i_sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sys_state_reg <= S_IDLE;
            req_tgl_reg   <= 1'b0;
            hold_reg      <= '0;
            done_reg      <= 1'b0;
        end else begin
            sys_state_reg <= sys_state_next;
            req_tgl_reg   <= req_tgl_next;
            hold_reg      <= hold_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        sys_state_next = sys_state_reg;
        req_tgl_next   = req_tgl_reg;
        hold_next      = hold_reg;
        done_next      = 1'b0;
        case (sys_state_reg)
            S_IDLE: begin
                if (i_tx_valid) begin
                    hold_next      = i_tx_data;
                    req_tgl_next   = ~req_tgl_reg;
                    sys_state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Ack toggle caught up with our request: word consumed.
                if (ack_sync == req_tgl_reg) begin
                    sys_state_next = S_IDLE;
                    done_next      = 1'b1;
                end
            end
            default: sys_state_next = S_IDLE;
        endcase
    end

    assign o_tx_ready = (sys_state_reg == S_IDLE);
    assign o_tx_done  = done_reg;

    // ------------------------------------------------------------------
    // CAN domain
    // ------------------------------------------------------------------
    can_state_t        can_state_reg, can_state_next;
    logic              req_seen_reg, req_seen_next;
    logic              ack_tgl_next;
    logic [DATA_W-1:0] can_data_reg, can_data_next;

    can_bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .i_clk   (i_can_clk),
        .i_reset (can_rst),
        .i_d     (req_tgl_reg),
        .o_q     (req_sync)
    );

    always_ff @(posedge i_can_clk or posedge can_rst) begin
        if (can_rst) begin
            can_state_reg <= C_IDLE;
            req_seen_reg  <= 1'b0;
            ack_tgl_reg   <= 1'b0;
            can_data_reg  <= '0;
        end else begin
            can_state_reg <= can_state_next;
            req_seen_reg  <= req_seen_next;
            ack_tgl_reg   <= ack_tgl_next;
            can_data_reg  <= can_data_next;
        end
    end

    always_comb begin
        can_state_next = can_state_reg;
        req_seen_next  = req_seen_reg;
        ack_tgl_next   = ack_tgl_reg;
        can_data_next  = can_data_reg;
        case (can_state_reg)
            C_IDLE: begin
                // hold_reg has been stable since before req_tgl toggled, so
                // sampling it here without a synchronizer is safe.
                if (req_sync != req_seen_reg) begin
                    can_data_next  = hold_reg;
                    req_seen_next  = req_sync;
                    can_state_next = C_PRESENT;
                end
            end
            C_PRESENT: begin
                if (i_can_accept) begin
                    ack_tgl_next   = ~ack_tgl_reg;
                    can_state_next = C_IDLE;
                end
            end
            default: can_state_next = C_IDLE;
        endcase
    end

    assign o_can_valid = (can_state_reg == C_PRESENT);
    assign o_can_data  = can_data_reg;

endmodule
